// File: rtl/load_store_unit.sv
// Data-side bridge from the core RAM port to a ready/valid data memory with byte lanes.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses (adds misalign_err).
module load_store_unit #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_read,
    input  logic        core_write,
    input  logic [1:0]  core_data_type,
    input  logic        core_load_unsigned,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        bus_err,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             is_load;
    logic [1:0]       lat_type;
    logic             lat_uns;
    logic [1:0]       lat_lane;

    logic             request;
    logic             misaligned;
    logic             timeout_hit;
    logic             abort;
    logic             load_done;
    logic [3:0]       be_new;
    logic [31:0]      wdata_new;
    logic [31:0]      rdata_ext;
    logic [31:0]      rdata_shift;
    logic [15:0]      half_sel;

    assign request     = core_read | core_write;
    assign mem_req     = (state == REQ);
    assign core_stall  = request & (state != DONE);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((core_data_type == 2'b01) && core_addr[0]) ||
                        (core_data_type[1] && (core_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Lane enables and replicated store data for the incoming request
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = core_wdata;
        case (core_data_type)
            2'b00: begin
                be_new    = 4'b0001 << core_addr[1:0];
                wdata_new = {4{core_wdata[7:0]}};
            end
            2'b01: begin
                be_new    = core_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{core_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Returned word: selected lane moved to bit 0, then extended
    always_comb begin
        rdata_shift = mem_rdata >> {lat_lane, 3'b000};
        half_sel    = lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_type)
            2'b00:   rdata_ext = {{24{~lat_uns & rdata_shift[7]}}, rdata_shift[7:0]};
            2'b01:   rdata_ext = {{16{~lat_uns & half_sel[15]}}, half_sel};
            default: rdata_ext = mem_rdata;
        endcase
    end

    // Completion takes priority over the timeout in the same cycle
    always_comb begin
        next_state = state;
        abort      = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (request) next_state = misaligned ? DONE : REQ;
            end
            REQ: begin
                if (mem_ready && !is_load) begin
                    next_state = DONE;
                end else if (timeout_hit) begin
                    next_state = DONE;
                    abort      = 1'b1;
                end else if (mem_ready) begin
                    next_state = WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    next_state = DONE;
                    load_done  = 1'b1;
                end else if (timeout_hit) begin
                    next_state = DONE;
                    abort      = 1'b1;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            is_load    <= 1'b0;
            lat_type   <= 2'b00;
            lat_uns    <= 1'b0;
            lat_lane   <= 2'b00;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
            bus_err    <= 1'b0;
        end else begin
            state   <= next_state;
            bus_err <= abort;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (state == REQ || state == WAIT_R) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == IDLE && request) begin
                is_load   <= ~core_write;
                lat_type  <= core_data_type;
                lat_uns   <= core_load_unsigned;
                lat_lane  <= core_addr[1:0];
                mem_we    <= core_write;
                mem_be    <= be_new;
                mem_addr  <= {core_addr[31:2], 2'b00};
                mem_wdata <= wdata_new;
            end
            if (load_done) begin
                core_rdata <= rdata_ext;
            end else if (abort && is_load) begin
                core_rdata <= '0;
            end else if (state == IDLE && request && misaligned && !core_write) begin
                core_rdata <= '0;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= (state == IDLE) && request && misaligned;
        end
    end
`endif

endmodule
